// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Multi-cycle RV32I-style integer ALU behind a valid/ready request and
//   response handshake. Non-shift operations take one EXEC cycle; shifts walk
//   one bit per SHIFT cycle; illegal encodings answer immediately with an
//   error flag.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  request valid          req_ready_o  idle, can accept
//   data1_i      operand A              data2_i      operand B / immediate
//   opcode_i     instruction opcode     func3_i/func7_i instruction fields
//   rsp_valid_o  response valid         rsp_ready_i  consumer accepts response
//   result_o     registered result      error_o      illegal encoding flag
//   busy_o       any state other than IDLE
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int unsigned REGISTER_SIZE = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REGISTER_SIZE-1:0] data1_i,
   input  logic [REGISTER_SIZE-1:0] data2_i,
   input  logic [6:0]               opcode_i,
   input  logic [2:0]               func3_i,
   input  logic [6:0]               func7_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [REGISTER_SIZE-1:0] result_o,
   output logic                     error_o,
   output logic                     busy_o
);

   localparam int unsigned SHAMT_W = $clog2(REGISTER_SIZE);

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR,  OP_AND
   } op_t;

   state_t                   state_q, state_d;
   op_t                      op_q, op_d;
   logic [REGISTER_SIZE-1:0] a_q, a_d;
   logic [REGISTER_SIZE-1:0] b_q, b_d;
   logic [REGISTER_SIZE-1:0] result_q, result_d;
   logic                     error_q, error_d;
   logic [SHAMT_W-1:0]       cnt_q, cnt_d;

   // Decode of the presented instruction fields
   op_t  dec_op;
   logic dec_legal;
   logic dec_shift;
   logic is_r;
   logic is_i;

   always_comb begin
      dec_op    = OP_ADD;
      dec_legal = 1'b1;
      is_r      = (opcode_i == OPC_R);
      is_i      = (opcode_i == OPC_I);
      case (func3_i)
         3'b000: begin
            // I-type ADDI has no SUB form, so func7 is don't-care there
            if (is_i || func7_i == F7_BASE) dec_op = OP_ADD;
            else if (func7_i == F7_ALT)     dec_op = OP_SUB;
            else                            dec_legal = 1'b0;
         end
         3'b001: begin
            dec_op = OP_SLL;
            if (func7_i != F7_BASE) dec_legal = 1'b0;
         end
         3'b101: begin
            if (func7_i == F7_BASE)     dec_op = OP_SRL;
            else if (func7_i == F7_ALT) dec_op = OP_SRA;
            else                        dec_legal = 1'b0;
         end
         3'b010: dec_op = OP_SLT;
         3'b011: dec_op = OP_SLTU;
         3'b100: dec_op = OP_XOR;
         3'b110: dec_op = OP_OR;
         default: dec_op = OP_AND;
      endcase
      // Remaining R-type ops only exist with a zero func7
      if (is_r && func7_i != F7_BASE &&
          func3_i != 3'b000 && func3_i != 3'b001 && func3_i != 3'b101)
         dec_legal = 1'b0;
      if (!is_r && !is_i) dec_legal = 1'b0;
      dec_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      error_d  = error_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               op_d    = dec_op;
               a_d     = data1_i;
               b_d     = data2_i;
               cnt_d   = data2_i[SHAMT_W-1:0];
               error_d = 1'b0;
               if (!dec_legal) begin
                  error_d  = 1'b1;
                  result_d = '0;
                  state_d  = DONE;
               end else if (dec_shift) begin
                  // Shift runs in place on the result register
                  result_d = data1_i;
                  state_d  = SHIFT;
               end else begin
                  state_d  = EXEC;
               end
            end
         end
         EXEC: begin
            case (op_q)
               OP_ADD:  result_d = a_q + b_q;
               OP_SUB:  result_d = a_q - b_q;
               OP_SLT:  result_d = ($signed(a_q) < $signed(b_q)) ? REGISTER_SIZE'(1) : '0;
               OP_SLTU: result_d = (a_q < b_q) ? REGISTER_SIZE'(1) : '0;
               OP_XOR:  result_d = a_q ^ b_q;
               OP_OR:   result_d = a_q | b_q;
               OP_AND:  result_d = a_q & b_q;
               default: result_d = '0;
            endcase
            state_d = DONE;
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               case (op_q)
                  OP_SLL:  result_d = {result_q[REGISTER_SIZE-2:0], 1'b0};
                  OP_SRA:  result_d = {result_q[REGISTER_SIZE-1], result_q[REGISTER_SIZE-1:1]};
                  default: result_d = {1'b0, result_q[REGISTER_SIZE-1:1]};
               endcase
               cnt_d = cnt_q - SHAMT_W'(1);
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            if (rsp_ready_i) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         error_q  <= error_d;
         cnt_q    <= cnt_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign result_o    = result_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed and randomized requests against a behavioural reference model
//   that computes result, error and response latency straight from the
//   instruction rules. Also exercises response backpressure and reset in the
//   middle of a shift.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int unsigned W = 32;
   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [W-1:0] data1_i;
   logic [W-1:0] data2_i;
   logic [6:0]   opcode_i;
   logic [2:0]   func3_i;
   logic [6:0]   func7_i;
   logic         rsp_valid_o;
   logic         rsp_ready_i;
   logic [W-1:0] result_o;
   logic         error_o;
   logic         busy_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   alu_sequencer #(.REGISTER_SIZE(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .data1_i     (data1_i),
      .data2_i     (data2_i),
      .opcode_i    (opcode_i),
      .func3_i     (func3_i),
      .func7_i     (func7_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .result_o    (result_o),
      .error_o     (error_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic, latency counted in cycles from the
   // accept edge to the first cycle with a valid response.
   function automatic void model(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [W-1:0] d1,
                                 input logic [W-1:0] d2, output logic err,
                                 output logic [W-1:0] res, output int unsigned lat);
      logic        r_t;
      logic        i_t;
      int unsigned sh;
      r_t = (opc == OPC_R);
      i_t = (opc == OPC_I);
      sh  = int'(d2 % W);
      err = 1'b0;
      res = '0;
      lat = 2;
      if (!r_t && !i_t) err = 1'b1;
      else begin
         case (f3)
            3'd0: if (i_t || f7 == 7'h00) res = d1 + d2;
                  else if (f7 == 7'h20) res = d1 - d2;
                  else err = 1'b1;
            3'd1: if (f7 == 7'h00) begin res = d1 << sh; lat = sh + 2; end
                  else err = 1'b1;
            3'd5: if (f7 == 7'h00) begin res = d1 >> sh; lat = sh + 2; end
                  else if (f7 == 7'h20) begin res = W'($signed(d1) >>> sh); lat = sh + 2; end
                  else err = 1'b1;
            3'd2: res = ($signed(d1) < $signed(d2)) ? 32'd1 : 32'd0;
            3'd3: res = (d1 < d2) ? 32'd1 : 32'd0;
            3'd4: res = d1 ^ d2;
            3'd6: res = d1 | d2;
            default: res = d1 & d2;
         endcase
         if (r_t && f7 != 7'h00 && f3 != 3'd0 && f3 != 3'd1 && f3 != 3'd5) err = 1'b1;
      end
      if (err) begin
         res = '0;
         lat = 1;
      end
   endfunction

   task automatic apply_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [W-1:0] d1, input logic [W-1:0] d2, input int unsigned bp);
      logic         e_err;
      logic [W-1:0] e_res;
      int unsigned  e_lat;
      int unsigned  cyc;
      logic [W-1:0] held_r;
      logic         held_e;
      model(opc, f3, f7, d1, d2, e_err, e_res, e_lat);
      @(negedge clk_i);
      check("idle_ready", {63'd0, req_ready_o}, 64'd1);
      opcode_i    = opc;
      func3_i     = f3;
      func7_i     = f7;
      data1_i     = d1;
      data2_i     = d2;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      data1_i     = $urandom;
      data2_i     = $urandom;
      cyc = 1;
      while (!rsp_valid_o && cyc < 64) begin
         @(negedge clk_i);
         cyc++;
      end
      check("latency", 64'(cyc), 64'(e_lat));
      check("result", 64'(result_o), 64'(e_res));
      check("error", {63'd0, error_o}, {63'd0, e_err});
      if (!rsp_valid_o) begin
         apply_reset();
         return;
      end
      check("done_busy", {63'd0, busy_o}, 64'd1);
      held_r = result_o;
      held_e = error_o;
      for (int unsigned i = 0; i < bp; i++) begin
         opcode_i    = ($urandom_range(0, 1) == 0) ? OPC_R : OPC_I;
         func3_i     = 3'($urandom);
         func7_i     = 7'h00;
         data1_i     = $urandom;
         data2_i     = $urandom;
         req_valid_i = 1'b1;
         @(negedge clk_i);
         check("bp_valid", {63'd0, rsp_valid_o}, 64'd1);
         check("bp_ready", {63'd0, req_ready_o}, 64'd0);
         check("bp_result", 64'(result_o), 64'(held_r));
         check("bp_error", {63'd0, error_o}, {63'd0, held_e});
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b0;
      check("hs_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      check("hs_req_ready", {63'd0, req_ready_o}, 64'd1);
      check("hs_busy", {63'd0, busy_o}, 64'd0);
   endtask

   initial begin
      int unsigned  sel;
      int unsigned  saw;
      logic [6:0]   opc;
      logic [6:0]   f7;
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      data1_i     = '0;
      data2_i     = '0;
      opcode_i    = '0;
      func3_i     = '0;
      func7_i     = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
      check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_result", 64'(result_o), 64'd0);
      check("rst_error", {63'd0, error_o}, 64'd0);

      run(OPC_R, 3'd0, 7'h00, 32'd5, 32'd7, 0);
      run(OPC_R, 3'd0, 7'h20, 32'd3, 32'd5, 1);
      run(OPC_R, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
      run(OPC_R, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
      run(OPC_I, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 2);
      run(OPC_I, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 0);
      run(OPC_I, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 0);
      run(OPC_I, 3'd1, 7'h00, 32'h0000_0001, 32'd31, 0);
      run(7'b0000011, 3'd0, 7'h00, 32'd5, 32'd7, 0);
      run(OPC_R, 3'd7, 7'h20, 32'd1, 32'd2, 3);
      run(OPC_I, 3'd1, 7'h20, 32'd1, 32'd2, 0);

      for (int unsigned n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      opc = OPC_R;
         else if (sel < 8) opc = OPC_I;
         else              opc = 7'($urandom);
         sel = $urandom_range(0, 5);
         if (sel < 3)      f7 = 7'h00;
         else if (sel < 5) f7 = 7'h20;
         else              f7 = 7'($urandom);
         run(opc, 3'($urandom), f7, $urandom, $urandom, $urandom_range(0, 3));
      end

      // Reset while shifting by 20: the response must never appear
      @(negedge clk_i);
      opcode_i    = OPC_R;
      func3_i     = 3'd5;
      func7_i     = 7'h00;
      data1_i     = $urandom;
      data2_i     = 32'd20;
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      saw = 0;
      repeat (3) begin
         check("shift_busy", {63'd0, busy_o}, 64'd1);
         if (rsp_valid_o) saw++;
         @(negedge clk_i);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("midrst_req_ready", {63'd0, req_ready_o}, 64'd1);
      check("midrst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      check("midrst_busy", {63'd0, busy_o}, 64'd0);
      check("midrst_result", 64'(result_o), 64'd0);
      check("midrst_error", {63'd0, error_o}, 64'd0);
      repeat (25) begin
         @(negedge clk_i);
         if (rsp_valid_o) saw++;
      end
      check("midrst_no_rsp", 64'(saw), 64'd0);

      run(OPC_R, 3'd4, 7'h00, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
